// File: rtl/hline_setup.sv
// Horizontal-line setup: orders the endpoints, divides the depth delta by the span, and
// computes the first-pixel addresses before launching the hline FSM.
module hline_setup #(
  parameter int LINE_STRIDE = 2560,
  parameter int PIX_BYTES   = 4
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] x1,
  input  logic [15:0] x2,
  input  logic [15:0] y,
  input  logic [31:0] z1_in,
  input  logic [31:0] z2_in,
  input  logic [31:0] color,
  input  logic [31:0] fb_base,
  input  logic [31:0] zb_base,
  output logic [31:0] fb_addr,
  output logic [31:0] zbuff_addr,
  output logic [31:0] dx,
  output logic [31:0] slope,
  output logic [31:0] z1,
  output logic [31:0] rem,
  output logic [31:0] err,
  output logic [31:0] rgbx,
  output logic        start,
  input  logic        fsm_done,
  output logic        busy,
  output logic        cmd_done
);

  // state     | meaning
  // S_IDLE    | waiting for a command, cmd_ready high
  // S_ORDER   | swap endpoints so x is ascending, derive span and dz
  // S_DIV     | 32 restoring-divide steps of |dz| by span
  // S_ADDR    | frame and z-buffer first-pixel addresses
  // S_START   | one-cycle launch pulse to the hline FSM
  // S_WAIT    | wait for fsm_done; first cycle ignores a stale level
  typedef enum logic [2:0] {S_IDLE, S_ORDER, S_DIV, S_ADDR, S_START, S_WAIT} state_t;

  localparam logic [31:0] STRIDE = 32'(LINE_STRIDE);
  localparam logic [31:0] PBYTES = 32'(PIX_BYTES);

  state_t state_q, state_d;

  logic [15:0] x1_q, x1_d, x2_q, x2_d, y_q, y_d;
  logic [31:0] za_q, za_d, zb_q, zb_d, color_q, color_d, fbb_q, fbb_d, zbb_q, zbb_d;
  logic [15:0] xmin_q, xmin_d, span_q, span_d, prem_q, prem_d;
  logic [31:0] quo_q, quo_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d, wfirst_q, wfirst_d, start_q, start_d;
  logic [31:0] fb_q, fb_d, zba_q, zba_d, dx_q, dx_d, slope_q, slope_d;
  logic [31:0] z1o_q, z1o_d, rem_q, rem_d, rgbx_q, rgbx_d;

  logic        swap;
  logic [15:0] xmin_c, xmax_c, span_c, prem_n;
  logic [31:0] zmin_c, zmax_c, dz_c, dz_abs_c, quo_n;
  logic [16:0] shl;
  logic        div_ok;

  always_comb begin
    swap     = x2_q < x1_q;
    xmin_c   = swap ? x2_q : x1_q;
    xmax_c   = swap ? x1_q : x2_q;
    zmin_c   = swap ? zb_q : za_q;
    zmax_c   = swap ? za_q : zb_q;
    span_c   = xmax_c - xmin_c;
    dz_c     = zmax_c - zmin_c;
    dz_abs_c = dz_c[31] ? -dz_c : dz_c;
    // partial remainder stays below span, so 17 bits hold the shifted value
    shl      = {prem_q, quo_q[31]};
    div_ok   = shl >= {1'b0, span_q};
    prem_n   = div_ok ? 16'(shl - {1'b0, span_q}) : shl[15:0];
    quo_n    = {quo_q[30:0], div_ok};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_valid) state_d = S_ORDER;
      S_ORDER: state_d = (span_c == 16'd0) ? S_ADDR : S_DIV;
      S_DIV:   if (cnt_q == 5'd0) state_d = S_ADDR;
      S_ADDR:  state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (!wfirst_q && fsm_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    cmd_done  = (state_q == S_WAIT) && !wfirst_q && fsm_done;
  end

  always_comb begin
    x1_d = x1_q;  x2_d = x2_q;  y_d = y_q;
    za_d = za_q;  zb_d = zb_q;  color_d = color_q;
    fbb_d = fbb_q;  zbb_d = zbb_q;
    xmin_d = xmin_q;  span_d = span_q;  neg_d = neg_q;
    quo_d = quo_q;  prem_d = prem_q;  cnt_d = cnt_q;
    fb_d = fb_q;  zba_d = zba_q;  dx_d = dx_q;  slope_d = slope_q;
    z1o_d = z1o_q;  rem_d = rem_q;  rgbx_d = rgbx_q;
    wfirst_d = (state_q == S_START);
    start_d  = (state_d == S_START);
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        x1_d = x1;  x2_d = x2;  y_d = y;
        za_d = z1_in;  zb_d = z2_in;  color_d = color;
        fbb_d = fb_base;  zbb_d = zb_base;
      end
      S_ORDER: begin
        xmin_d  = xmin_c;
        span_d  = span_c;
        neg_d   = dz_c[31];
        quo_d   = dz_abs_c;
        prem_d  = 16'd0;
        cnt_d   = 5'd31;
        dx_d    = {16'd0, span_c} + 32'd1;
        z1o_d   = zmin_c;
        rgbx_d  = color_q;
        slope_d = 32'd0;
        rem_d   = 32'd0;
      end
      S_DIV: begin
        quo_d  = quo_n;
        prem_d = prem_n;
        cnt_d  = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          slope_d = neg_q ? -quo_n : quo_n;
          rem_d   = {16'd0, prem_n};
        end
      end
      S_ADDR: begin
        fb_d  = fbb_q + {16'd0, y_q} * STRIDE + {16'd0, xmin_q} * PBYTES;
        zba_d = zbb_q + {16'd0, y_q} * STRIDE + {16'd0, xmin_q} * PBYTES;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      x1_q <= '0;  x2_q <= '0;  y_q <= '0;
      za_q <= '0;  zb_q <= '0;  color_q <= '0;
      fbb_q <= '0;  zbb_q <= '0;
      xmin_q <= '0;  span_q <= '0;  neg_q <= 1'b0;
      quo_q <= '0;  prem_q <= '0;  cnt_q <= '0;
      wfirst_q <= 1'b0;  start_q <= 1'b0;
      fb_q <= '0;  zba_q <= '0;  dx_q <= '0;  slope_q <= '0;
      z1o_q <= '0;  rem_q <= '0;  rgbx_q <= '0;
    end else begin
      x1_q <= x1_d;  x2_q <= x2_d;  y_q <= y_d;
      za_q <= za_d;  zb_q <= zb_d;  color_q <= color_d;
      fbb_q <= fbb_d;  zbb_q <= zbb_d;
      xmin_q <= xmin_d;  span_q <= span_d;  neg_q <= neg_d;
      quo_q <= quo_d;  prem_q <= prem_d;  cnt_q <= cnt_d;
      wfirst_q <= wfirst_d;  start_q <= start_d;
      fb_q <= fb_d;  zba_q <= zba_d;  dx_q <= dx_d;  slope_q <= slope_d;
      z1o_q <= z1o_d;  rem_q <= rem_d;  rgbx_q <= rgbx_d;
    end
  end

  assign fb_addr    = fb_q;
  assign zbuff_addr = zba_q;
  assign dx         = dx_q;
  assign slope      = slope_q;
  assign z1         = z1o_q;
  assign rem        = rem_q;
  assign err        = 32'd0;
  assign rgbx       = rgbx_q;
  assign start      = start_q;

endmodule

// File: tb/tb_hline_setup.sv
// Directed bench for hline_setup: hand-computed line setups, timing, done handshake and reset abort.
module tb_hline_setup;

  logic        clk, nreset, cmd_valid, cmd_ready, start, fsm_done, busy, cmd_done;
  logic [15:0] x1, x2, y;
  logic [31:0] z1_in, z2_in, color, fb_base, zb_base;
  logic [31:0] fb_addr, zbuff_addr, dx, slope, z1, rem, err, rgbx;

  int n_checks = 0;
  int n_fail   = 0;

  hline_setup #(.LINE_STRIDE(2560), .PIX_BYTES(4)) dut (
    .clk(clk), .nreset(nreset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .x1(x1), .x2(x2), .y(y), .z1_in(z1_in), .z2_in(z2_in), .color(color),
    .fb_base(fb_base), .zb_base(zb_base), .fb_addr(fb_addr), .zbuff_addr(zbuff_addr),
    .dx(dx), .slope(slope), .z1(z1), .rem(rem), .err(err), .rgbx(rgbx),
    .start(start), .fsm_done(fsm_done), .busy(busy), .cmd_done(cmd_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] yy,
                      input logic [31:0] za, input logic [31:0] zb, input logic [31:0] col,
                      input logic [31:0] fbb, input logic [31:0] zbb);
    x1 = a;  x2 = b;  y = yy;  z1_in = za;  z2_in = zb;
    color = col;  fb_base = fbb;  zb_base = zbb;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // lat counts cycles after the accept cycle T; start in T+lat
  task automatic wait_start(output int lat);
    lat = 1;
    while (!start && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!start) lat = 999;
  endtask

  task automatic run_line(input string tag,
                          input logic [15:0] a, input logic [15:0] b, input logic [15:0] yy,
                          input logic [31:0] za, input logic [31:0] zb,
                          input logic [31:0] fbb, input logic [31:0] zbb,
                          input int e_lat, input logic [31:0] e_dx, input logic [31:0] e_slope,
                          input logic [31:0] e_rem, input logic [31:0] e_z1,
                          input logic [31:0] e_fb, input logic [31:0] e_zb);
    int lat;
    chk({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
    send(a, b, yy, za, zb, 32'hA5B6C7D8, fbb, zbb);
    wait_start(lat);
    chk({tag, "_lat"}, lat, e_lat);
    chk({tag, "_dx"}, dx, e_dx);
    chk({tag, "_slope"}, slope, e_slope);
    chk({tag, "_rem"}, rem, e_rem);
    chk({tag, "_z1"}, z1, e_z1);
    chk({tag, "_fb"}, fb_addr, e_fb);
    chk({tag, "_zb"}, zbuff_addr, e_zb);
    chk({tag, "_rgbx"}, rgbx, 32'hA5B6C7D8);
    chk({tag, "_err"}, err, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_start_1cyc"}, {31'd0, start}, 32'd0);
    @(posedge clk); #1;
    fsm_done = 1'b1;
    #1;
    chk({tag, "_done"}, {31'd0, cmd_done}, 32'd1);
    chk({tag, "_slope_hold"}, slope, e_slope);
    @(posedge clk); #1;
    fsm_done = 1'b0;
    chk({tag, "_done_1cyc"}, {31'd0, cmd_done}, 32'd0);
    chk({tag, "_idle"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    int lat, ndone, nstart;
    nreset = 1'b0;  cmd_valid = 1'b0;  fsm_done = 1'b0;
    x1 = '0;  x2 = '0;  y = '0;  z1_in = '0;  z2_in = '0;
    color = '0;  fb_base = '0;  zb_base = '0;
    #3;
    chk("rst_fb", fb_addr, 32'd0);
    chk("rst_dx", dx, 32'd0);
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, cmd_done}, 32'd0);
    @(posedge clk); #1;
    nreset = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);

    run_line("fwd", 16'd10, 16'd19, 16'd2, 32'd100, 32'd145, 32'h1000_0000, 32'h2000_0000,
             35, 32'd10, 32'd5, 32'd0, 32'd100, 32'h1000_1428, 32'h2000_1428);
    run_line("swp", 16'd19, 16'd10, 16'd2, 32'd145, 32'd100, 32'h1000_0000, 32'h2000_0000,
             35, 32'd10, 32'd5, 32'd0, 32'd100, 32'h1000_1428, 32'h2000_1428);
    run_line("neg", 16'd0, 16'd4, 16'd0, 32'd20, 32'd7, 32'h0000_0100, 32'h0000_0200,
             35, 32'd5, 32'hFFFF_FFFD, 32'd1, 32'd20, 32'h0000_0100, 32'h0000_0200);
    run_line("pt", 16'd7, 16'd7, 16'd1, 32'd50, 32'd60, 32'h0, 32'h0,
             3, 32'd1, 32'd0, 32'd0, 32'd50, 32'h0000_0A1C, 32'h0000_0A1C);
    run_line("swneg", 16'd30, 16'd3, 16'd5, 32'd0, 32'd1000, 32'h4000_0000, 32'h5000_0000,
             35, 32'd28, 32'hFFFF_FFDB, 32'd1, 32'd1000, 32'h4000_320C, 32'h5000_320C);

    // stale done level across START and first wait cycle
    fsm_done = 1'b1;
    send(16'd10, 16'd19, 16'd2, 32'd100, 32'd145, 32'h11, 32'h1000_0000, 32'h2000_0000);
    wait_start(lat);
    chk("stale_lat", lat, 35);
    chk("stale_done_start", {31'd0, cmd_done}, 32'd0);
    @(posedge clk); #1;
    chk("stale_done_wait1", {31'd0, cmd_done}, 32'd0);
    cmd_valid = 1'b1;  x1 = 16'd1;  x2 = 16'd2;
    fsm_done = 1'b0;
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      ndone += int'(cmd_done);
      chk("busy_no_accept", {31'd0, cmd_ready}, 32'd0);
    end
    chk("stale_early_done", ndone, 0);
    fsm_done = 1'b1;
    #1;
    chk("stale_late_done", {31'd0, cmd_done}, 32'd1);
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    fsm_done = 1'b0;
    chk("stale_back_idle", {31'd0, busy}, 32'd0);
    chk("stale_dx_kept", dx, 32'd10);
    @(posedge clk); #1;
    chk("ignored_cmd", {31'd0, busy}, 32'd0);

    // reset mid-divide
    send(16'd0, 16'd4, 16'd0, 32'd20, 32'd7, 32'h22, 32'h100, 32'h200);
    repeat (9) @(posedge clk);
    #1;
    nreset = 1'b0;
    #1;
    chk("abort_fb", fb_addr, 32'd0);
    chk("abort_dx", dx, 32'd0);
    chk("abort_rgbx", rgbx, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    nreset = 1'b1;
    nstart = 0;  ndone = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      nstart += int'(start);
      ndone  += int'(cmd_done);
    end
    chk("abort_no_start", nstart, 0);
    chk("abort_no_done", ndone, 0);
    chk("abort_ready", {31'd0, cmd_ready}, 32'd1);

    run_line("post", 16'd7, 16'd7, 16'd1, 32'd50, 32'd60, 32'h0, 32'h0,
             3, 32'd1, 32'd0, 32'd0, 32'd50, 32'h0000_0A1C, 32'h0000_0A1C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hline_setup.md
HLINE_SETUP -- requirements
Module: hline_setup

Interface
REQ-001 SHALL have parameter LINE_STRIDE, default 2560, frame/z-buffer row pitch in bytes.
REQ-002 SHALL have parameter PIX_BYTES, default 4, bytes per pixel and per z word.
REQ-003 SHALL have a single clock; reset is asynchronous and active-low. Ports:
clk  in  1  sole clock, rising edge
nreset  in  1  async active-low reset
cmd_valid  in  1  line command present
cmd_ready  out  1  high only in IDLE
x1, x2  in  16  endpoint x, unsigned
y  in  16  scanline, unsigned
z1_in, z2_in  in  32  endpoint depth, signed
color  in  32  RGBX fill value
fb_base, zb_base  in  32  buffer base byte addresses
fb_addr, zbuff_addr  out  32  first-pixel addresses to hline FSM
dx  out  32  pixel count of line
slope  out  32  signed integer z step per pixel
z1  out  32  depth at leftmost pixel
rem  out  32  unsigned remainder of |dz|/span
err  out  32  initial error term
rgbx  out  32  registered color
start  out  1  one-cycle launch pulse to hline FSM
fsm_done  in  1  level done from hline FSM
busy  out  1  high in every state except IDLE
cmd_done  out  1  one-cycle pulse, line finished

Function
REQ-004 SHALL implement states IDLE, ORDER, DIV, ADDR, START, WAIT_DONE.
REQ-005 SHALL accept a command only when cmd_valid and cmd_ready are both high (cycle T), capturing all command inputs; cmd_valid in other states is ignored.
REQ-006 ORDER (T+1): if x2 < x1, swap x and z endpoints; xmin/zmin = left end; span = xmax - xmin (16-bit); dz = zmax_side - zmin (32-bit signed, two's complement wrap).
REQ-007 dx SHALL equal span + 1, zero-extended; z1 SHALL equal depth at xmin; err SHALL equal 0; rgbx SHALL equal captured color.
REQ-008 If span != 0, DIV SHALL run a restoring unsigned divide of |dz| by span, one quotient bit per cycle, exactly 32 cycles (T+2..T+33).
REQ-009 slope SHALL equal quotient negated when dz < 0, else quotient; rem SHALL equal the unsigned remainder regardless of sign.
REQ-010 If span == 0, DIV SHALL be skipped (ORDER -> ADDR), slope = 0, rem = 0.
REQ-011 ADDR: fb_addr = fb_base + y*LINE_STRIDE + xmin*PIX_BYTES; zbuff_addr same with zb_base; all arithmetic mod 2^32.
REQ-012 START: start high for exactly one cycle (T+35, or T+3 when span == 0); next state WAIT_DONE.
REQ-013 WAIT_DONE SHALL ignore fsm_done on its first cycle (stale DONE level from previous line), then on first sampled fsm_done high: pulse cmd_done for one cycle and return to IDLE.
REQ-014 All outputs to the hline FSM SHALL be registered and held constant from START through the cycle cmd_done is high.
REQ-015 A new command may be accepted in the cycle after cmd_done.

Reset
REQ-016 On nreset low, asynchronously: state = IDLE, all output registers = 0, start = 0, cmd_done = 0, busy = 0; cmd_ready = 1 after release.
REQ-017 Reset asserted mid-operation SHALL abort the line with no start or cmd_done pulse emitted afterwards.

Verification
REQ-018 x1=10,x2=19,y=2,z1_in=100,z2_in=145,fb_base=0x10000000,zb_base=0x20000000 -> start at T+35, dx=10, slope=5, rem=0, z1=100, fb_addr=0x10001428, zbuff_addr=0x20001428.
REQ-019 Same line with endpoints swapped (x1=19,z1_in=145,x2=10,z2_in=100) -> identical outputs and timing to REQ-018.
REQ-020 x1=0,x2=4,z1_in=20,z2_in=7 -> dx=5, slope=0xFFFFFFFD, rem=1, z1=20.
REQ-021 x1=x2=7 -> start at T+3, dx=1, slope=0, rem=0.
REQ-022 fsm_done held high through START and first WAIT_DONE cycle, then low, then high 5 cycles later -> cmd_done once, only after the later assertion; cmd_valid during busy not accepted.
REQ-023 nreset low at T+10 mid-DIV -> outputs 0 immediately, no start after release, cmd_ready high.
